time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Time-of-day controller for the Artix-7 clock. It sequences the entry of hours, minutes and seconds from debounced push-button pulses and advances running time on a 1 Hz tick. It presents BCD digits to the seven-segment driver and the current mode code. It sits between the button debouncers and the display multiplexer and owns the only copy of the time registers.

## Interface
- `AUTO_EXIT`, default 10: number of `sec_tick` pulses with no button activity in a set state before the block returns to RUN. 0 disables the timeout.
- `HRS_MAX`, default 23: highest hour value.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `sec_tick` in 1: single-cycle 1 Hz strobe.
- `run_en` in 1: 1 lets time advance in RUN; 0 freezes it.
- `btn_mode` in 1: single-cycle pulse, debounced upstream; advances the mode.
- `btn_up` in 1: single-cycle pulse; increments the field being edited.
- `btn_down` in 1: single-cycle pulse; decrements the field being edited.
- `mode` out 3: 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HRS.
- `hrs_tens`, `hrs_ones`, `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: BCD digits.
- `blink_mask` out 6: per-digit blank request, bit 5 = `hrs_tens` down to bit 0 = `sec_ones`.

## Operation
- State machine states: RUN, SET_HRS, SET_MIN, SET_SEC.
- Mode transitions on `btn_mode`: RUN → SET_HRS → SET_MIN → SET_SEC → RUN.
- Time is held internally as binary: hrs 5 bits, min 6 bits, sec 6 bits. Digits are split combinationally from the registers.
- In RUN with `run_en`=1, each `sec_tick` increments the time:
  - sec wraps 59→0 with a carry to min.
  - min wraps 59→0 with a carry to hrs.
  - hrs wraps `HRS_MAX`→0.
  - 23:59:59 becomes 00:00:00 in a single tick.
- In RUN, `btn_up` and `btn_down` are ignored.
- In any set state, `sec_tick` does not advance the time.
- In a set state, `btn_up` increments the selected field modulo its range (59→0, `HRS_MAX`→0). There is no carry into the neighbouring field.
- In a set state, `btn_down` decrements the selected field (0→59, 0→`HRS_MAX`).
- Simultaneous events:
  - `btn_up` and `btn_down` together are ignored.
  - `btn_mode` together with `btn_up` or `btn_down`: `btn_mode` wins, and the field is unchanged.
- Inactivity timeout: an idle counter clears on any button pulse and on every mode change. It increments on `sec_tick` while in a set state.
  - When the counter reaches `AUTO_EXIT`, the state goes to RUN and the edited values are kept.
- Reset values: state RUN, time 00:00:00, all digits 0, `mode`=0, `blink_mask`=0, idle counter 0.

## Timing
- All outputs are registered, or decoded from registers only. They update on the cycle after the triggering input is sampled high.
- Increment latency: `sec_tick` at edge N → new time visible after edge N+1.
- Button latency: pulse at edge N → new field value or new `mode` after edge N+1.
- `sec_tick` coinciding with `btn_mode` in RUN: the block enters SET_HRS and the tick is dropped.
- `reset_n` low at any edge, including mid-edit, forces the reset values on that edge.
- `btn_mode` pulses are one per cycle. Back-to-back pulses advance one state per cycle.

## Configuration
- Macro `TIME_SET_BLINK_EN`, defined:
  - A blink phase bit toggles on each `sec_tick` in set states and clears on entry to any set state.
  - While the phase is 1, `blink_mask` drives 1 on the two digits of the field being edited.
  - In RUN, `blink_mask` is 0.
- Macro undefined: no phase logic is built. `blink_mask` is tied to 0, and the port stays present.

## Structure
- Package `clock_pkg` holds:
  - the state enum, with its encoding equal to the `mode` codes;
  - the constants `SEC_MAX`=59 and `MIN_MAX`=59;
  - the BCD digit width.
- One sub-module, `bin2bcd_2d`: combinational 0–63 → tens/ones split, instantiated three times.
- Field arithmetic (inc/dec with wrap) is a shared function in `clock_pkg`.

## Test plan
- Wrap and carry: reset, set 23:59:59 through the set states, return to RUN, one `sec_tick` → `hrs_tens`..`sec_ones` = 0,0,0,0,0,0; `mode`=0.
- Mode sequence: 4× `btn_mode` → `mode` = 3,2,1,0. In SET_HRS, `btn_down` from 0 → hrs=23. In SET_MIN, 59× `btn_up` from 0 → 59, one more → 0, with hrs unchanged.
- Freeze:
  - `run_en`=0 with 5 `sec_tick` in RUN → time unchanged.
  - In SET_SEC, 5 `sec_tick` → sec unchanged.
- Timeout: `AUTO_EXIT`=10, enter SET_MIN, set min=42, 10 `sec_tick` with no buttons → `mode`=0, min=42. 9 ticks then `btn_up` then 9 ticks → still `mode`=2.
- Simultaneous events:
  - `btn_up`+`btn_down` together in SET_HRS → no change.
  - `btn_mode`+`btn_up` → `mode` advances, hrs unchanged.
  - `reset_n`=0 mid-edit → 00:00:00, `mode`=0 on the next edge.
- Blink (macro defined): in SET_HRS after one `sec_tick` → `blink_mask`=6'b110000; after a second tick → 0. Macro undefined → always 0.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: state encoding (equal to the mode codes), field limits, digit width
// and the shared wrap-around inc/dec used for both editing and running time.
package clock_pkg;
  typedef enum logic [2:0] {RUN = 3'd0, SET_SEC = 3'd1, SET_MIN = 3'd2, SET_HRS = 3'd3} state_e;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam int DIG_W = 4;
  function automatic logic [5:0] field_step(input logic [5:0] v, input logic [5:0] max,
                                            input logic up, input logic dn);
    return (up && !dn) ? ((v == max) ? 6'd0 : v + 6'd1) :
           (dn && !up) ? ((v == 6'd0) ? max : v - 6'd1) : v;
  endfunction
endpackage

// File: rtl/bin2bcd_2d.sv
// bin2bcd_2d: combinational split of a 0-63 binary value into tens/ones BCD digits.
module bin2bcd_2d
  import clock_pkg::*;
(
  input  logic [5:0]       bin_i,
  output logic [DIG_W-1:0] tens_o,
  output logic [DIG_W-1:0] ones_o
);
  assign tens_o = DIG_W'(bin_i / 6'd10);
  assign ones_o = DIG_W'(bin_i % 6'd10);
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-of-day register, button-driven set sequence and 1 Hz advance.
// Optional TIME_SET_BLINK_EN builds the blink phase for the field being edited.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int AUTO_EXIT = 10,
  parameter int HRS_MAX   = 23
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sec_tick,
  input  logic             run_en,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [2:0]       mode,
  output logic [DIG_W-1:0] hrs_tens,
  output logic [DIG_W-1:0] hrs_ones,
  output logic [DIG_W-1:0] min_tens,
  output logic [DIG_W-1:0] min_ones,
  output logic [DIG_W-1:0] sec_tens,
  output logic [DIG_W-1:0] sec_ones,
  output logic [5:0]       blink_mask
);
  localparam int IW = $clog2(AUTO_EXIT + 2);
  localparam logic [5:0] HMAX = 6'(HRS_MAX);
  localparam logic [IW-1:0] EXIT_N = IW'(AUTO_EXIT);
  state_e state_q, state_d, state_nx;
  logic [4:0] hrs_q, hrs_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [IW-1:0] idle_q, idle_d;
  logic set_st, act, edit, tick_run, expire;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      idle_q  <= idle_d;
    end
  end
  // btn_mode has priority over field edits and over a coincident tick
  always_comb begin
    set_st   = state_q != RUN;
    act      = btn_mode | btn_up | btn_down;
    edit     = set_st && !btn_mode;
    tick_run = !set_st && !btn_mode && sec_tick && run_en;
    expire   = AUTO_EXIT != 0 && set_st && !act && sec_tick && (idle_q + IW'(1)) == EXIT_N;
    state_nx = state_q == RUN ? SET_HRS : state_q == SET_HRS ? SET_MIN :
               state_q == SET_MIN ? SET_SEC : RUN;
    state_d  = btn_mode ? state_nx : expire ? RUN : state_q;
    sec_d    = (edit && state_q == SET_SEC) ? field_step(sec_q, SEC_MAX, btn_up, btn_down) :
               tick_run ? field_step(sec_q, SEC_MAX, 1'b1, 1'b0) : sec_q;
    min_d    = (edit && state_q == SET_MIN) ? field_step(min_q, MIN_MAX, btn_up, btn_down) :
               (tick_run && sec_q == SEC_MAX) ? field_step(min_q, MIN_MAX, 1'b1, 1'b0) : min_q;
    hrs_d    = 5'((edit && state_q == SET_HRS) ? field_step({1'b0, hrs_q}, HMAX, btn_up, btn_down) :
               (tick_run && sec_q == SEC_MAX && min_q == MIN_MAX) ?
               field_step({1'b0, hrs_q}, HMAX, 1'b1, 1'b0) : {1'b0, hrs_q});
    idle_d   = (act || !set_st || expire) ? '0 : idle_q + IW'(sec_tick);
  end
  assign mode = state_q;
  bin2bcd_2d u_hrs (.bin_i({1'b0, hrs_q}), .tens_o(hrs_tens), .ones_o(hrs_ones));
  bin2bcd_2d u_min (.bin_i(min_q), .tens_o(min_tens), .ones_o(min_ones));
  bin2bcd_2d u_sec (.bin_i(sec_q), .tens_o(sec_tens), .ones_o(sec_ones));
`ifdef TIME_SET_BLINK_EN
  logic blink_q, blink_d;
  always_comb blink_d = (state_d == RUN || state_d != state_q) ? 1'b0 : blink_q ^ sec_tick;
  always_ff @(posedge clk) begin
    if (!reset_n) blink_q <= 1'b0;
    else blink_q <= blink_d;
  end
  assign blink_mask = !blink_q ? 6'b000000 : state_q == SET_HRS ? 6'b110000 :
                      state_q == SET_MIN ? 6'b001100 : state_q == SET_SEC ? 6'b000011 : 6'b000000;
`else
  assign blink_mask = '0;
`endif
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: vector table, corner sequences and a random run, all scored
// against a seconds-of-day reference model.
module tb_time_set_ctrl;
  localparam int AUTO_EXIT = 10;
  localparam int HRS_MAX   = 23;
`ifdef TIME_SET_BLINK_EN
  localparam logic [5:0] BLINK_H = 6'b110000;
`else
  localparam logic [5:0] BLINK_H = 6'b000000;
`endif
  logic clk = 0, reset_n = 0, sec_tick = 0, run_en = 1, btn_mode = 0, btn_up = 0, btn_down = 0;
  logic [2:0] mode;
  logic [3:0] hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [5:0] blink_mask;
  logic [23:0] digits;
  int n_chk = 0, n_err = 0;
  int h = 0, m = 0, s = 0, pos = 0, idle = 0, ph = 0;
  typedef struct {logic [4:0] in; logic [23:0] dig; logic [2:0] md;} vec_t;
  vec_t tbl[20];

  time_set_ctrl #(.AUTO_EXIT(AUTO_EXIT), .HRS_MAX(HRS_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick), .run_en(run_en),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
    .hrs_tens(hrs_tens), .hrs_ones(hrs_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .blink_mask(blink_mask));

  always #5 clk = ~clk;
  assign digits = {hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pack(input int hh, input int mm, input int ss);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [5:0] exp_blink();
`ifdef TIME_SET_BLINK_EN
    return (ph == 0 || pos == 0) ? 6'b000000 : pos == 1 ? 6'b110000 : pos == 2 ? 6'b001100 : 6'b000011;
`else
    return 6'b000000;
`endif
  endfunction

  // pos walks RUN, SET_HRS, SET_MIN, SET_SEC; running time is one seconds-of-day count
  task automatic model(input bit mb, input bit u, input bit d, input bit t, input bit r, input bit rn);
    if (!rn) begin
      h = 0; m = 0; s = 0; pos = 0; idle = 0; ph = 0;
    end else if (mb) begin
      pos = (pos + 1) % 4; idle = 0; ph = 0;
    end else if (pos == 0) begin
      idle = 0; ph = 0;
      if (t && r) begin
        int tot;
        tot = ((h * 60 + m) * 60 + s + 1) % ((HRS_MAX + 1) * 3600);
        h = tot / 3600; m = (tot / 60) % 60; s = tot % 60;
      end
    end else begin
      if (u ^ d) begin
        int dl;
        dl = u ? 1 : -1;
        if (pos == 1) h = (h + dl + HRS_MAX + 1) % (HRS_MAX + 1);
        else if (pos == 2) m = (m + dl + 60) % 60;
        else s = (s + dl + 60) % 60;
      end
      if (u || d) idle = 0;
      else if (t) idle++;
      if (AUTO_EXIT != 0 && idle == AUTO_EXIT) begin
        pos = 0; idle = 0; ph = 0;
      end else if (t) ph ^= 1;
    end
  endtask

  task automatic cyc(input bit mb, input bit u, input bit d, input bit t, input bit r, input bit rn);
    btn_mode = mb; btn_up = u; btn_down = d; sec_tick = t; run_en = r; reset_n = rn;
    @(posedge clk);
    #1;
    btn_mode = 0; btn_up = 0; btn_down = 0; sec_tick = 0; reset_n = 1;
    model(mb, u, d, t, r, rn);
    chk("model_time", 32'(digits), 32'(pack(h, m, s)));
    chk("model_mode", 32'(mode), (pos == 0) ? 32'd0 : 32'(4 - pos));
    chk("model_blink", 32'(blink_mask), 32'(exp_blink()));
  endtask

  task automatic rep(input int n, input bit mb, input bit u, input bit d, input bit t, input bit r);
    for (int i = 0; i < n; i++) cyc(mb, u, d, t, r, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{5'b00011, 24'h000001, 3'd0};
    tbl[1]  = '{5'b00011, 24'h000002, 3'd0};
    tbl[2]  = '{5'b01001, 24'h000002, 3'd0};
    tbl[3]  = '{5'b10001, 24'h000002, 3'd3};
    tbl[4]  = '{5'b00101, 24'h230002, 3'd3};
    tbl[5]  = '{5'b01001, 24'h000002, 3'd3};
    tbl[6]  = '{5'b01001, 24'h010002, 3'd3};
    tbl[7]  = '{5'b01101, 24'h010002, 3'd3};
    tbl[8]  = '{5'b11001, 24'h010002, 3'd2};
    tbl[9]  = '{5'b00101, 24'h015902, 3'd2};
    tbl[10] = '{5'b00011, 24'h015902, 3'd2};
    tbl[11] = '{5'b10001, 24'h015902, 3'd1};
    tbl[12] = '{5'b01001, 24'h015903, 3'd1};
    tbl[13] = '{5'b10001, 24'h015903, 3'd0};
    tbl[14] = '{5'b10011, 24'h015903, 3'd3};
    tbl[15] = '{5'b10001, 24'h015903, 3'd2};
    tbl[16] = '{5'b10001, 24'h015903, 3'd1};
    tbl[17] = '{5'b10001, 24'h015903, 3'd0};
    tbl[18] = '{5'b00010, 24'h015903, 3'd0};
    tbl[19] = '{5'b00011, 24'h015904, 3'd0};
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rst_time", 32'(digits), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_blink", 32'(blink_mask), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], 1'b1);
      chk($sformatf("vec%0d_time", i), 32'(digits), 32'(tbl[i].dig));
      chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(tbl[i].md));
    end
    // 23:59:59 wraps to midnight in one tick
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1); cyc(0, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1); cyc(0, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1); cyc(0, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("wrap_pre", 32'(digits), 32'h235959);
    cyc(0, 0, 0, 1, 1, 1);
    chk("wrap_time", 32'(digits), 32'h000000);
    chk("wrap_mode", 32'(mode), 32'd0);
    // minute field wraps without touching hours
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1); cyc(0, 1, 0, 0, 1, 1); cyc(1, 0, 0, 0, 1, 1);
    rep(59, 0, 1, 0, 0, 1);
    chk("min59", 32'(digits), 32'h015900);
    cyc(0, 1, 0, 0, 1, 1);
    chk("min_wrap", 32'(digits), 32'h010000);
    chk("min_mode", 32'(mode), 32'd2);
    rep(2, 1, 0, 0, 0, 1);
    rep(5, 0, 0, 0, 1, 0);
    chk("freeze_run", 32'(digits), 32'h010000);
    rep(3, 1, 0, 0, 0, 1);
    rep(5, 0, 0, 0, 1, 1);
    chk("freeze_set", 32'(digits), 32'h010000);
    chk("freeze_mode", 32'(mode), 32'd1);
    cyc(1, 0, 0, 0, 1, 1);
    // inactivity timeout and its restart on a button
    cyc(0, 0, 0, 0, 1, 0);
    rep(2, 1, 0, 0, 0, 1);
    rep(42, 0, 1, 0, 0, 1);
    rep(9, 0, 0, 0, 1, 1);
    chk("to_9", 32'(mode), 32'd2);
    cyc(0, 0, 0, 1, 1, 1);
    chk("to_mode", 32'(mode), 32'd0);
    chk("to_time", 32'(digits), 32'h004200);
    rep(2, 1, 0, 0, 0, 1);
    rep(9, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 1, 1);
    rep(9, 0, 0, 0, 1, 1);
    chk("to_restart_mode", 32'(mode), 32'd2);
    chk("to_restart_time", 32'(digits), 32'h004300);
    cyc(0, 1, 0, 0, 1, 0);
    chk("rst_edit_time", 32'(digits), 32'd0);
    chk("rst_edit_mode", 32'(mode), 32'd0);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    chk("blink_1", 32'(blink_mask), 32'(BLINK_H));
    cyc(0, 0, 0, 1, 1, 1);
    chk("blink_2", 32'(blink_mask), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 499) != 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
